fpu_request_issuer: RTL and testbench

Initiator side of the Fixed_Point_Unit operand/operation/result/ready interface. It accepts one fixed-point operation request from the core over a valid/ready handshake and drives operands and operation code to the FPU. It holds them stable until the FPU raises ready, or until a timeout expires. It then returns the captured result over a second valid/ready handshake. It sits between the execute stage and the FPU and guarantees a single outstanding FPU operation.

---
 rtl/fpu_request_issuer.sv | 142 ++++++++++++++
 tb/tb_fpu_request_issuer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fpu_request_issuer.sv
// Initiator for the fixed-point unit: accepts one request, holds operands on the FPU
// until it reports ready (or the wait budget runs out), then hands back the result.
module fpu_request_issuer #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_operand_1,
    input  logic [WIDTH-1:0] req_operand_2,
    input  logic [1:0]       req_operation,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_timeout,
    output logic [WIDTH-1:0] fpu_operand_1,
    output logic [WIDTH-1:0] fpu_operand_2,
    output logic [1:0]       fpu_operation,
    input  logic [WIDTH-1:0] fpu_result,
    input  logic             fpu_ready
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [CW-1:0]    cnt_r, cnt_nxt_s;
    logic             req_ready_r, rsp_valid_r, rsp_timeout_r;
    logic             rsp_timeout_nxt_s;
    logic [WIDTH-1:0] rsp_result_r, rsp_result_nxt_s;
    logic [WIDTH-1:0] op1_r, op2_r, op1_nxt_s, op2_nxt_s;
    logic [1:0]       opc_r, opc_nxt_s;
    logic             accept_s;

    // req_ready_r is low for the first cycle out of reset, so acceptance also needs it
    assign accept_s = (state_r == ST_IDLE) && req_valid && req_ready_r;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; ISSUE never looks at fpu_ready so a stale ready is masked
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_ISSUE;
                else          state_nxt_s = ST_IDLE;
            end
            ST_ISSUE: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (fpu_ready || (cnt_r == CNT_LAST)) state_nxt_s = ST_RESP;
                else                                  state_nxt_s = ST_WAIT;
            end
            ST_RESP: begin
                if (rsp_ready) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_RESP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the datapath registers; ready beats timeout on the last wait edge
    always_comb begin
        cnt_nxt_s         = cnt_r;
        rsp_result_nxt_s  = rsp_result_r;
        rsp_timeout_nxt_s = rsp_timeout_r;
        op1_nxt_s         = op1_r;
        op2_nxt_s         = op2_r;
        opc_nxt_s         = opc_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    op1_nxt_s = req_operand_1;
                    op2_nxt_s = req_operand_2;
                    opc_nxt_s = req_operation;
                    cnt_nxt_s = '0;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_WAIT: begin
                if (fpu_ready) begin
                    rsp_result_nxt_s  = fpu_result;
                    rsp_timeout_nxt_s = 1'b0;
                end else if (cnt_r == CNT_LAST) begin
                    rsp_result_nxt_s  = '0;
                    rsp_timeout_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end
            end
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r         <= '0;
            req_ready_r   <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_result_r  <= '0;
            rsp_timeout_r <= 1'b0;
            op1_r         <= '0;
            op2_r         <= '0;
            opc_r         <= 2'd0;
        end else begin
            cnt_r         <= cnt_nxt_s;
            req_ready_r   <= (state_nxt_s == ST_IDLE);
            rsp_valid_r   <= (state_nxt_s == ST_RESP);
            rsp_result_r  <= rsp_result_nxt_s;
            rsp_timeout_r <= rsp_timeout_nxt_s;
            op1_r         <= op1_nxt_s;
            op2_r         <= op2_nxt_s;
            opc_r         <= opc_nxt_s;
        end
    end

    assign req_ready     = req_ready_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_result    = rsp_result_r;
    assign rsp_timeout   = rsp_timeout_r;
    assign fpu_operand_1 = op1_r;
    assign fpu_operand_2 = op2_r;
    assign fpu_operation = opc_r;

endmodule

// File: tb/tb_fpu_request_issuer.sv
// Directed bench for fpu_request_issuer with a small behavioural FPU and TIMEOUT=8.
module tb_fpu_request_issuer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [31:0] req_operand_1, req_operand_2;
    logic [1:0]  req_operation;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_result;
    logic [31:0] fpu_operand_1, fpu_operand_2, fpu_result;
    logic [1:0]  fpu_operation;
    logic        fpu_ready;
    logic [63:0] prod_s;

    int errors = 0;
    int checks = 0;

    fpu_request_issuer #(.WIDTH(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_operand_1(req_operand_1), .req_operand_2(req_operand_2),
        .req_operation(req_operation),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
        .fpu_operand_1(fpu_operand_1), .fpu_operand_2(fpu_operand_2),
        .fpu_operation(fpu_operation),
        .fpu_result(fpu_result), .fpu_ready(fpu_ready)
    );

    always #5 clk = ~clk;

    // Q22.10 FPU model: add, sub, mul, and operand passthrough for sqrt
    always_comb begin
        prod_s = {32'd0, fpu_operand_1} * {32'd0, fpu_operand_2};
        case (fpu_operation)
            2'd0:    fpu_result = fpu_operand_1 + fpu_operand_2;
            2'd1:    fpu_result = fpu_operand_1 - fpu_operand_2;
            2'd2:    fpu_result = prod_s[41:10];
            default: fpu_result = fpu_operand_1;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and returns just after the accepting edge E0
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        req_operand_1 = a;
        req_operand_2 = b;
        req_operation = op;
        req_valid     = 1'b1;
        tick();
        req_valid     = 1'b0;
    endtask

    task automatic complete();
        rsp_ready = 1'b1;
        tick();
        chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
        chk("idle_ready", {31'd0, req_ready}, 32'd1);
        rsp_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; fpu_ready = 1'b0;
        req_operand_1 = 32'd0; req_operand_2 = 32'd0; req_operation = 2'd0;

        // Reset
        repeat (3) tick();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
        chk("rst_op1", fpu_operand_1, 32'd0);
        chk("rst_op2", fpu_operand_2, 32'd0);
        chk("rst_opc", {30'd0, fpu_operation}, 32'd0);
        reset = 1'b1;
        tick();
        chk("rel_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rel_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // ADD with ready always high
        fpu_ready = 1'b1;
        send(32'h0000_0C00, 32'h0000_0400, 2'd0);
        chk("add_op1", fpu_operand_1, 32'h0000_0C00);
        chk("add_op2", fpu_operand_2, 32'h0000_0400);
        chk("add_opc", {30'd0, fpu_operation}, 32'd0);
        chk("add_busy", {31'd0, req_ready}, 32'd0);
        tick();
        chk("add_e1_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        chk("add_e2_valid", {31'd0, rsp_valid}, 32'd1);
        chk("add_result", rsp_result, 32'h0000_1000);
        chk("add_timeout", {31'd0, rsp_timeout}, 32'd0);
        complete();

        // MUL with late ready and response backpressure
        fpu_ready = 1'b0;
        send(32'h0000_0800, 32'h0000_0C00, 2'd2);
        repeat (5) tick();
        chk("mul_e5_valid", {31'd0, rsp_valid}, 32'd0);
        fpu_ready = 1'b1;
        tick();
        fpu_ready = 1'b0;
        chk("mul_e6_valid", {31'd0, rsp_valid}, 32'd1);
        chk("mul_result", rsp_result, 32'h0000_1800);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_result", rsp_result, 32'h0000_1800);
            chk("bp_timeout", {31'd0, rsp_timeout}, 32'd0);
            chk("bp_op1", fpu_operand_1, 32'h0000_0800);
            chk("bp_opc", {30'd0, fpu_operation}, 32'd2);
        end
        complete();

        // Stale ready during ISSUE must be ignored
        send(32'h0000_1000, 32'h0000_0400, 2'd1);
        fpu_ready = 1'b1;
        tick();
        fpu_ready = 1'b0;
        chk("stale_e1", {31'd0, rsp_valid}, 32'd0);
        tick();
        chk("stale_e2", {31'd0, rsp_valid}, 32'd0);
        tick();
        chk("stale_e3", {31'd0, rsp_valid}, 32'd0);
        fpu_ready = 1'b1;
        tick();
        fpu_ready = 1'b0;
        chk("stale_e4", {31'd0, rsp_valid}, 32'd1);
        chk("stale_result", rsp_result, 32'h0000_0C00);
        complete();

        // Timeout with no ready at all
        send(32'h0000_1234, 32'h0000_1111, 2'd0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("to_wait_valid", {31'd0, rsp_valid}, 32'd0);
        end
        tick();
        chk("to_e9_valid", {31'd0, rsp_valid}, 32'd1);
        chk("to_flag", {31'd0, rsp_timeout}, 32'd1);
        chk("to_result", rsp_result, 32'd0);
        complete();

        // Ready on the final wait edge wins over timeout
        send(32'h0000_1234, 32'h0000_1111, 2'd0);
        repeat (8) tick();
        chk("late_e8_valid", {31'd0, rsp_valid}, 32'd0);
        fpu_ready = 1'b1;
        tick();
        fpu_ready = 1'b0;
        chk("late_e9_valid", {31'd0, rsp_valid}, 32'd1);
        chk("late_flag", {31'd0, rsp_timeout}, 32'd0);
        chk("late_result", rsp_result, 32'h0000_2345);
        complete();

        // Requests during WAIT are ignored, then reset aborts the operation
        send(32'h0000_5000, 32'h0000_0300, 2'd3);
        tick();
        tick();
        req_operand_1 = 32'hFFFF_FFFF; req_operand_2 = 32'hEEEE_EEEE; req_operation = 2'd1;
        req_valid = 1'b1;
        tick();
        chk("ign_op1", fpu_operand_1, 32'h0000_5000);
        chk("ign_op2", fpu_operand_2, 32'h0000_0300);
        chk("ign_opc", {30'd0, fpu_operation}, 32'd3);
        chk("ign_ready", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_op1", fpu_operand_1, 32'd0);
        chk("mid_rst_op2", fpu_operand_2, 32'd0);
        chk("mid_rst_opc", {30'd0, fpu_operation}, 32'd0);
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        fpu_ready = 1'b1;
        send(32'h0000_0A00, 32'h0000_0600, 2'd0);
        tick();
        tick();
        fpu_ready = 1'b0;
        chk("post_rst_valid", {31'd0, rsp_valid}, 32'd1);
        chk("post_rst_result", rsp_result, 32'h0000_1000);
        chk("post_rst_timeout", {31'd0, rsp_timeout}, 32'd0);
        complete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
